// File: rtl/triangle_rom_arb_if.sv
// Request/grant and ROM port bundle for the triangle ROM arbiter.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface triangle_rom_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 10,
    parameter int DW      = 16
);
    logic                  en;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] addr;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [DW-1:0]         rdata;
    logic                  rerr;
    logic [AW-1:0]         rom_addr;
    logic [DW-1:0]         rom_doa;
    logic                  busy;

    modport master (
        output en, req, addr, rom_doa,
        input  gnt, rvalid, rdata, rerr, rom_addr, busy
    );

    modport slave (
        input  en, req, addr, rom_doa,
        output gnt, rvalid, rdata, rerr, rom_addr, busy
    );
endinterface

// File: rtl/triangle_rom_arb.sv
// Round-robin arbiter sharing one single-port triangle ROM between NUM_REQ requesters.
// Grants are combinational; read data returns one cycle later with an out-of-range flag.
module triangle_rom_arb #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 10,
    parameter int DW      = 16,
    parameter int DEPTH   = 990
) (
    input logic               clka,
    input logic               rsta,
    triangle_rom_arb_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] valid_q, gnt_d;
    logic               err_q, err_d;
    logic [AW-1:0]      romAddr_q, romAddr_d;

    logic               winFound;
    logic [PW-1:0]      winIdx;
    logic [AW-1:0]      winAddr;
    logic               winOor;
    logic               grant;
    logic [NUM_REQ-1:0] rvalidInt;

    // Search starts at the pointer and wraps; the first active request wins.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!winFound && bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
                winFound = 1'b1;
                winIdx   = PW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt_d = '0;
        grant = winFound && bus.en && !rsta;
        if (grant) begin
            gnt_d[winIdx] = 1'b1;
        end
        winAddr = bus.addr[int'(winIdx)*AW +: AW];
        winOor  = int'(winAddr) >= DEPTH;
    end

    // Out-of-range reads park the ROM at address 0; the error travels with the valid bit.
    always_comb begin
        romAddr_d = romAddr_q;
        ptr_d     = ptr_q;
        err_d     = 1'b0;
        if (grant) begin
            romAddr_d = winOor ? '0 : winAddr;
            ptr_d     = (int'(winIdx) == NUM_REQ - 1) ? '0 : winIdx + PW'(1);
            err_d     = winOor;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            ptr_q     <= '0;
            valid_q   <= '0;
            err_q     <= 1'b0;
            romAddr_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            valid_q   <= gnt_d;
            err_q     <= err_d;
            romAddr_q <= romAddr_d;
        end
    end

    // A read granted just before reset is suppressed while reset is high.
    always_comb begin
        rvalidInt  = rsta ? '0 : valid_q;
        bus.rvalid = rvalidInt;
        bus.busy   = |rvalidInt;
        bus.rerr   = (|rvalidInt) && err_q;
        bus.rdata  = ((|rvalidInt) && !err_q) ? bus.rom_doa : '0;
    end

    assign bus.gnt      = gnt_d;
    assign bus.rom_addr = romAddr_d;
endmodule
